// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state encoding
// and the digit-counter sizing rule.
package serial_adder_pkg;

  // Two-bit state encoding for the control FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for N digits: one spare bit so the value N itself fits
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit combinational ripple adder built from full_adder cells.
// Besides the carry out it exposes the carry into its top bit, which the
// top level uses to form the signed-overflow flag on the final digit.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);
  // c[i] is the carry into bit i; c[DIGIT] leaves the digit
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit. Operands are captured on start, then
// consumed DIGIT bits per clock LSB first; the result digits are shifted
// into the top of a partial-sum register so that after N = WIDTH/DIGIT
// steps the register holds the full sum. Subtraction is a + ~b + 1, with
// the +1 injected as the initial carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  // Reject illegal geometries at elaboration time
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
  end

  state_e            state_q;
  logic [WIDTH-1:0]  opa_q, opb_q, psum_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]  sum_q;

  // Next values of the shift registers for one RUN step
  logic [WIDTH-1:0]  opa_d, opb_d, psum_d;
  logic [DIGIT-1:0]  dsum;
  logic              dco, dcmsb;
  logic              last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (opa_q[DIGIT-1:0]),
    .y    (opb_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s    (dsum),
    .co   (dco),
    .cmsb (dcmsb)
  );

  // With a single digit the whole operand is consumed in one step, so the
  // shifted-out operands are empty and the partial sum is just the digit.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign opa_d  = '0;
    assign opb_d  = '0;
    assign psum_d = dsum;
  end else begin : g_multi_digit
    assign opa_d  = {{DIGIT{1'b0}}, opa_q[WIDTH-1:DIGIT]};
    assign opb_d  = {{DIGIT{1'b0}}, opb_q[WIDTH-1:DIGIT]};
    assign psum_d = {dsum, psum_q[WIDTH-1:DIGIT]};
  end

  assign last = (cnt_q == LAST_CNT);

  // Control FSM with operand/partial-sum datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            psum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          opa_q   <= opa_d;
          opb_q   <= opb_d;
          psum_q  <= psum_d;
          carry_q <= dco;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            sum_q   <= psum_d;
            cout_q  <= dco;
            ovf_q   <= dcmsb ^ dco;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five geometries run in parallel, each with its own
// DUT, expected-result queue and done-driven monitor.
module tb_serial_adder;

  localparam int NCFG    = 5;
  localparam int MAX_CYC = 50000;

  function automatic int cfg_w(input int i);
    return (i < 2) ? 8 : 4;
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  // Hand-computed 8-bit vectors: a, b, sub -> sum, cout, ovf
  localparam int NV = 8;
  localparam logic [7:0] TA [NV] = '{8'h5A, 8'h10, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h80};
  localparam logic [7:0] TB [NV] = '{8'h3C, 8'h20, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h80};
  localparam logic       TS [NV] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
  localparam logic [7:0] ES [NV] = '{8'h96, 8'hF0, 8'h00, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h00};
  localparam logic       EC [NV] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
  localparam logic       EO [NV] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};

  logic clk = 1'b0;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   fin_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int w, input int d, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL W%0d/D%0d %s: got 0x%0h, expected 0x%0h", w, d, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = cfg_w(g);
    localparam int D  = cfg_d(g);
    localparam int N  = W / D;
    localparam int PE = (N + 1 < 3) ? N + 1 : 3;  // edge of the ignored start pulse
    localparam int RE = (N < 3) ? N : 3;          // edge of the aborting reset

    logic         rst, start, sub, busy, done, cout, ovf;
    logic [W-1:0] a, b, sum;

    logic [W+1:0] res_q [$];
    int           cyc_q [$];

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
    );

    // Independent reference: full-width add, plus a (W-1)-bit add for the
    // carry into the MSB.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
      logic [W-1:0] yy;
      logic [W:0]   full;
      logic [W-1:0] low;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
      low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(s);
      return {full[W-1:0], full[W], low[W-1] ^ full[W]};
    endfunction

    // Issue one operation and queue its expected result and done cycle
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input logic [W+1:0] er);
      int n;
      a = ta; b = tb; sub = ts; start = 1'b1;
      res_q.push_back(er);
      cyc_q.push_back(cyc + 1 + N);
      tick();
      start = 1'b0; a = ~ta; b = ~tb; sub = ~ts;
      n = 0;
      while (busy && n < N + 4) begin
        tick();
        n++;
      end
      chk(W, D, "busy_cycles", 64'(n), 64'(N + 1));
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
      if (done === 1'b1) begin
        if (res_q.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL W%0d/D%0d spurious_done: got done=1, expected done=0 (nothing pending)", W, D);
        end else begin
          chk(W, D, "result{sum,cout,ovf}", 64'({sum, cout, ovf}), 64'(res_q.pop_front()));
          chk(W, D, "done_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
        end
      end
    end

    initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk(W, D, "reset_state", 64'({busy, done, sum, cout, ovf}), 64'(0));

      if (W == 8) begin
        for (int i = 0; i < NV; i++)
          run_op(W'(TA[i]), W'(TB[i]), TS[i], {W'(ES[i]), EC[i], EO[i]});
      end else begin
        for (int x = 0; x < (1 << W); x++)
          for (int y = 0; y < (1 << W); y++)
            for (int s = 0; s < 2; s++)
              run_op(W'(x), W'(y), s[0], model(W'(x), W'(y), s[0]));
      end

      // start pulsed while busy is dropped
      a = W'(8'h11); b = W'(8'h22); sub = 1'b0; start = 1'b1;
      res_q.push_back({W'(8'h33), 1'b0, 1'b0});
      cyc_q.push_back(cyc + 1 + N);
      tick();
      start = 1'b0;
      repeat (PE - 1) tick();
      a = '1; b = '1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (N + 4) tick();
      chk(W, D, "ignored_start_busy", 64'(busy), 64'(0));
      chk(W, D, "held_sum", 64'(sum), 64'(W'(8'h33)));

      // reset in mid-operation aborts with no done pulse
      a = W'(8'h05); b = W'(8'h03); start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RE - 1) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(W, D, "abort_outputs", 64'({busy, done, sum, cout, ovf}), 64'(0));
      repeat (N + 3) tick();

      // reset and start together: reset wins
      rst = 1'b1; start = 1'b1; a = '1; b = '1;
      tick();
      chk(W, D, "rst_start_busy", 64'(busy), 64'(0));
      rst = 1'b0; start = 1'b0;
      tick();
      chk(W, D, "rst_start_idle", 64'({busy, done}), 64'(0));
      repeat (N + 3) tick();
      chk(W, D, "queue_drained", 64'(res_q.size()), 64'(0));
      fin_cnt++;
    end
  end

  initial begin
    int k;
    k = 0;
    while (fin_cnt < NCFG && k < MAX_CYC) begin
      @(posedge clk);
      k++;
    end
    if (fin_cnt < NCFG) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL timeout: got %0d configs finished, expected %0d", fin_cnt, NCFG);
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
